instr_fetch: RTL and testbench

//  - Instruction fetch stage: owns the PC and issues word fetches on the instruction bus.
//  - Buffers returned instructions with their PC in a slot FIFO and presents them to the decode stage over a valid/ready handshake.
//  - Decode consumes if_instruction as its `instruction` input.
//  - Accepts branch/jump redirects from execute, flushing buffered and in-flight fetches.

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches and buffers returned words for decode.
// Optional misaligned-redirect exception enabled by defining IFU_MISALIGN_EXC_EN.
module instr_fetch #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              FIFO_DEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst_b,
   output logic            ibus_req,
   output logic [XLEN-1:0] ibus_addr,
   input  logic            ibus_ready,
   input  logic            ibus_rvalid,
   input  logic [XLEN-1:0] ibus_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] if_instruction,
   output logic [XLEN-1:0] if_pc,
   output logic            if_misaligned
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   logic [XLEN-1:0]  pc;
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [PTR_W-1:0] fill_ptr;
   logic [CNT_W-1:0] used_cnt;
   logic [CNT_W-1:0] unfilled_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic             misaligned_q;

   logic [XLEN-1:0]  slot_pc    [FIFO_DEPTH];
   logic [XLEN-1:0]  slot_instr [FIFO_DEPTH];

   logic [CNT_W:0]   occupancy;
   logic             alloc;
   logic             pop;
   logic             resp_fill;
   logic             resp_drop;
   logic             resp_retire;
   logic [XLEN-1:0]  redirect_target;
   logic             redirect_bad;

`ifdef IFU_MISALIGN_EXC_EN
   assign redirect_target = redirect_pc;
   assign redirect_bad    = (redirect_pc[1:0] != 2'b00);
`else
   assign redirect_target = redirect_pc & ~XLEN'(3);
   assign redirect_bad    = 1'b0;
`endif

   // Slots already allocated plus responses still owed to a flushed stream bound new requests.
   assign occupancy = {1'b0, used_cnt} + {1'b0, drop_cnt};
   assign ibus_req  = rst_b && !redirect && !misaligned_q && (occupancy < DEPTH_C);
   assign ibus_addr = pc;

   assign alloc       = ibus_req && ibus_ready;
   assign if_valid    = (used_cnt != unfilled_cnt);
   assign pop         = if_valid && id_ready;
   assign resp_drop   = ibus_rvalid && (drop_cnt != '0);
   assign resp_fill   = ibus_rvalid && (drop_cnt == '0) && (unfilled_cnt != '0);
   assign resp_retire = ibus_rvalid && ((drop_cnt != '0) || (unfilled_cnt != '0));

   assign if_pc          = slot_pc[head_ptr];
   assign if_instruction = slot_instr[head_ptr];
   assign if_misaligned  = misaligned_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pc           <= RESET_VECTOR;
         head_ptr     <= '0;
         tail_ptr     <= '0;
         fill_ptr     <= '0;
         used_cnt     <= '0;
         unfilled_cnt <= '0;
         drop_cnt     <= '0;
         misaligned_q <= 1'b0;
      end else if (redirect) begin
         head_ptr     <= '0;
         tail_ptr     <= '0;
         fill_ptr     <= '0;
         used_cnt     <= '0;
         unfilled_cnt <= '0;
         // Every still-owed response becomes a drop; one arriving now retires one of them.
         drop_cnt     <= drop_cnt + unfilled_cnt - CNT_W'(resp_retire);
         if (redirect_bad) begin
            misaligned_q <= 1'b1;
         end else begin
            misaligned_q <= 1'b0;
            pc           <= redirect_target;
         end
      end else begin
         if (alloc) begin
            tail_ptr <= tail_ptr + PTR_W'(1);
            pc       <= pc + XLEN'(4);
         end
         if (resp_fill) fill_ptr <= fill_ptr + PTR_W'(1);
         if (pop)       head_ptr <= head_ptr + PTR_W'(1);
         if (resp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
         used_cnt     <= used_cnt + CNT_W'(alloc) - CNT_W'(pop);
         unfilled_cnt <= unfilled_cnt + CNT_W'(alloc) - CNT_W'(resp_fill);
      end
   end

   // NOTE: slot payloads carry no reset; occupancy counters alone decide what is valid.
   always_ff @(posedge clk) begin
      if (alloc)     slot_pc[tail_ptr]    <= pc;
      if (resp_fill) slot_instr[fill_ptr] <= ibus_rdata;
   end

`ifndef SYNTHESIS
   rvalid_expected : assert property (@(posedge clk) disable iff (!rst_b)
      ibus_rvalid |-> ((drop_cnt != '0) || (unfilled_cnt != '0)));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch (default FIFO_DEPTH=2, RESET_VECTOR=0).
// Expectations for the misaligned-redirect rows follow IFU_MISALIGN_EXC_EN when it is defined.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ready;
   logic        ibus_rvalid;
   logic [31:0] ibus_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic        if_misaligned;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .ibus_req       (ibus_req),
      .ibus_addr      (ibus_addr),
      .ibus_ready     (ibus_ready),
      .ibus_rvalid    (ibus_rvalid),
      .ibus_rdata     (ibus_rdata),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .id_ready       (id_ready),
      .if_instruction (if_instruction),
      .if_pc          (if_pc),
      .if_misaligned  (if_misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          do_rst;
      bit          ready;
      bit          rvalid;
      logic [31:0] rdata;
      bit          redir;
      logic [31:0] rpc;
      bit          id_rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
      bit          e_mis;
   } vec_t;

   vec_t vecs[$];

   // Memory image: every word encodes its own address so stale data is recognisable.
   function automatic logic [31:0] ins(input logic [31:0] a);
      return 32'hC0DE_0000 | a;
   endfunction

   function automatic vec_t mk(input int rs, input int rdy, input int rv, input logic [31:0] rd,
                               input int red, input logic [31:0] rp, input int idr,
                               input int ereq, input logic [31:0] ea, input int ev,
                               input logic [31:0] epc, input int emis);
      vec_t t;
      t.do_rst = (rs != 0);   t.ready  = (rdy != 0); t.rvalid  = (rv != 0); t.rdata = rd;
      t.redir  = (red != 0);  t.rpc    = rp;         t.id_rdy  = (idr != 0);
      t.e_req  = (ereq != 0); t.e_addr = ea;         t.e_valid = (ev != 0); t.e_pc  = epc;
      t.e_mis  = (emis != 0);
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      ibus_ready = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
   endtask

   task automatic apply_reset();
      rst_b = 1'b0;
      drive_idle();
      @(posedge clk); #1;
      rst_b = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // rs rdy rv rdata        red rpc        idr  ereq eaddr         ev epc     emis
      // Straight-line fetch, then a 5-cycle decode stall.
      vecs.push_back(mk(1, 1, 0, 0,          0, 0, 1,  1, 32'h0,  0, 0,      0));
      vecs.push_back(mk(0, 1, 1, ins(0),     0, 0, 1,  1, 32'h4,  0, 0,      0));
      vecs.push_back(mk(0, 1, 1, ins(4),     0, 0, 1,  0, 0,      1, 32'h0,  0));
      vecs.push_back(mk(0, 1, 0, 0,          0, 0, 1,  1, 32'h8,  1, 32'h4,  0));
      vecs.push_back(mk(0, 1, 1, ins(8),     0, 0, 1,  1, 32'hC,  0, 0,      0));
      vecs.push_back(mk(0, 1, 1, ins(32'hC), 0, 0, 1,  0, 0,      1, 32'h8,  0));
      vecs.push_back(mk(0, 1, 0, 0,          0, 0, 0,  1, 32'h10, 1, 32'hC,  0));
      vecs.push_back(mk(0, 1, 1, ins(32'h10),0, 0, 0,  0, 0,      1, 32'hC,  0));
      vecs.push_back(mk(0, 1, 0, 0,          0, 0, 0,  0, 0,      1, 32'hC,  0));
      vecs.push_back(mk(0, 1, 0, 0,          0, 0, 0,  0, 0,      1, 32'hC,  0));
      vecs.push_back(mk(0, 1, 0, 0,          0, 0, 0,  0, 0,      1, 32'hC,  0));
      vecs.push_back(mk(0, 1, 0, 0,          0, 0, 1,  0, 0,      1, 32'hC,  0));
      vecs.push_back(mk(0, 1, 0, 0,          0, 0, 1,  1, 32'h14, 1, 32'h10, 0));
      // Redirect with two fetches in flight, then ibus_ready low for three cycles.
      vecs.push_back(mk(1, 1, 0, 0,           0, 0,      1, 1, 32'h0,   0, 0,       0));
      vecs.push_back(mk(0, 1, 0, 0,           0, 0,      1, 1, 32'h4,   0, 0,       0));
      vecs.push_back(mk(0, 1, 0, 0,           1, 32'h100,1, 0, 0,       0, 0,       0));
      vecs.push_back(mk(0, 1, 1, 32'hDEADBEEF,0, 0,      1, 0, 0,       0, 0,       0));
      vecs.push_back(mk(0, 1, 1, 32'hDEADBEEF,0, 0,      1, 1, 32'h100, 0, 0,       0));
      vecs.push_back(mk(0, 1, 1, ins(32'h100),0, 0,      1, 1, 32'h104, 0, 0,       0));
      vecs.push_back(mk(0, 1, 1, ins(32'h104),0, 0,      1, 0, 0,       1, 32'h100, 0));
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,      1, 1, 32'h108, 1, 32'h104, 0));
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,      1, 1, 32'h108, 0, 0,       0));
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,      1, 1, 32'h108, 0, 0,       0));
      vecs.push_back(mk(0, 1, 0, 0,           0, 0,      1, 1, 32'h108, 0, 0,       0));
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,      1, 1, 32'h10C, 0, 0,       0));
      vecs.push_back(mk(0, 0, 1, ins(32'h108),0, 0,      1, 1, 32'h10C, 0, 0,       0));
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,      1, 1, 32'h10C, 1, 32'h108, 0));
      // Redirect in the same cycle as a response and a pop.
      vecs.push_back(mk(1, 1, 0, 0,           0, 0,       1, 1, 32'h0,   0, 0,       0));
      vecs.push_back(mk(0, 1, 1, ins(0),      0, 0,       1, 1, 32'h4,   0, 0,       0));
      vecs.push_back(mk(0, 1, 1, ins(4),      1, 32'h100, 1, 0, 0,       1, 32'h0,   0));
      vecs.push_back(mk(0, 1, 0, 0,           0, 0,       1, 1, 32'h100, 0, 0,       0));
      vecs.push_back(mk(0, 0, 1, ins(32'h100),0, 0,       1, 1, 32'h104, 0, 0,       0));
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,       1, 1, 32'h104, 1, 32'h100, 0));
      // Misaligned redirect target, then an aligned one.
      vecs.push_back(mk(1, 0, 0, 0,           0, 0,       1, 1, 32'h0,   0, 0,       0));
      vecs.push_back(mk(0, 0, 0, 0,           1, 32'h102, 1, 0, 0,       0, 0,       0));
`ifdef IFU_MISALIGN_EXC_EN
      vecs.push_back(mk(0, 1, 0, 0,           0, 0,       1, 0, 0,       0, 0,       1));
      vecs.push_back(mk(0, 1, 0, 0,           1, 32'h200, 1, 0, 0,       0, 0,       1));
`else
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,       1, 1, 32'h100, 0, 0,       0));
      vecs.push_back(mk(0, 1, 0, 0,           1, 32'h200, 1, 0, 0,       0, 0,       0));
`endif
      vecs.push_back(mk(0, 1, 0, 0,           0, 0,       1, 1, 32'h200, 0, 0,       0));
      vecs.push_back(mk(0, 1, 1, ins(32'h200),0, 0,       1, 1, 32'h204, 0, 0,       0));
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,       1, 0, 0,       1, 32'h200, 0));
      // PC wraps modulo 2^32.
      vecs.push_back(mk(1, 0, 0, 0,           1, 32'hFFFF_FFFC, 1, 0, 0,            0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,           0, 0,             1, 1, 32'hFFFF_FFFC, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,           0, 0,             1, 1, 32'h0,         0, 0, 0));

      rst_b = 1'b0;
      drive_idle();
      #1;
      check("reset ibus_req", {31'b0, ibus_req}, 32'd0);
      check("reset if_valid", {31'b0, if_valid}, 32'd0);
      check("reset if_misaligned", {31'b0, if_misaligned}, 32'd0);
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) apply_reset();
         ibus_ready  = vecs[i].ready;
         ibus_rvalid = vecs[i].rvalid;
         ibus_rdata  = vecs[i].rdata;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         id_ready    = vecs[i].id_rdy;
         @(negedge clk);
         check($sformatf("row%0d ibus_req", i), {31'b0, ibus_req}, {31'b0, vecs[i].e_req});
         if (vecs[i].e_req)
            check($sformatf("row%0d ibus_addr", i), ibus_addr, vecs[i].e_addr);
         check($sformatf("row%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
         check($sformatf("row%0d if_misaligned", i), {31'b0, if_misaligned}, {31'b0, vecs[i].e_mis});
         if (vecs[i].e_valid) begin
            check($sformatf("row%0d if_pc", i), if_pc, vecs[i].e_pc);
            check($sformatf("row%0d if_instruction", i), if_instruction, ins(vecs[i].e_pc));
         end
         @(posedge clk); #1;
      end

      // Reset asserted mid-operation with two fetches outstanding.
      apply_reset();
      ibus_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ibus_ready = 1'b0;
      #2;
      rst_b = 1'b0;
      #1;
      check("midreset ibus_req", {31'b0, ibus_req}, 32'd0);
      check("midreset if_valid", {31'b0, if_valid}, 32'd0);
      @(posedge clk); #1;
      rst_b = 1'b1;
      ibus_ready = 1'b1;
      @(negedge clk);
      check("postreset ibus_req", {31'b0, ibus_req}, 32'd1);
      check("postreset ibus_addr", ibus_addr, 32'h0);
      @(posedge clk); #1;
      ibus_ready  = 1'b0;
      ibus_rvalid = 1'b1;
      ibus_rdata  = ins(32'h0);
      @(posedge clk); #1;
      ibus_rvalid = 1'b0;
      for (int k = 0; k < 10 && !if_valid; k++) @(negedge clk);
      check("postreset if_valid wait", {31'b0, if_valid}, 32'd1);
      check("postreset if_pc", if_pc, 32'h0);
      check("postreset if_instruction", if_instruction, ins(32'h0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
